ddfs_sweep_controller: RTL and testbench
========================================

// Module: ddfs_sweep_controller
// PURPOSE
//  Sequencer that drives the freq_C2 input of the DDFS frequency converter with a programmed sweep.
//  Steps linearly from f_start to f_stop by f_step, holding each frequency for dwell clock cycles.
//  Sits between the user/config interface and DDFS_frequency_converter.
//  freq_valid marks each new applied frequency, so downstream fw/freq_control registers update once per step.
// PARAMETERS
//  FREQ_W   23        width of all frequency values (Hz, unsigned)
//  DWELL_W  24        width of dwell counter
//  MAX_FREQ 5000000   largest legal frequency (Hz); larger start/stop values are rejected
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  start      in   1        sweep request; sampled only in IDLE
//  abort      in   1        stop sweep; return to IDLE
//  mode_loop  in   1        1: restart at f_start after f_stop; 0: single sweep
//  f_start    in   FREQ_W   first frequency
//  f_stop     in   FREQ_W   last frequency
//  f_step     in   FREQ_W   step magnitude; direction is implied by start/stop ordering
//  dwell      in   DWELL_W  cycles per frequency; 0 is treated as 1
//  freq_C2    out  FREQ_W   frequency to converter, registered
//  freq_valid out  1        1-cycle pulse; high in the same cycle freq_C2 takes a new value
//  busy       out  1        high while a sweep is active
//  done       out  1        1-cycle pulse at single-sweep completion
//  err        out  1        1-cycle pulse when a start request is rejected
// BEHAVIOUR
//  Reset: state=IDLE; freq_C2=0; freq_valid=busy=done=err=0; dwell counter=0.
//  FSM: IDLE -> DWELL -> (DWELL | IDLE). Next-frequency compute is combinational at dwell expiry.
//  IDLE, start=1, request illegal -> err=1 next cycle; stay IDLE; freq_C2 unchanged.
//   Illegal: f_start>MAX_FREQ, f_stop>MAX_FREQ, or (f_step==0 and f_start!=f_stop).
//  IDLE, start=1, request legal -> latch all config inputs; direction up = (f_stop>=f_start).
//   Next cycle: freq_C2=f_start, freq_valid=1, busy=1, cnt=max(dwell,1); state=DWELL.
//  Config inputs are ignored after latch; start while busy is ignored.
//  DWELL: cnt decrements each cycle; on the cycle cnt==1:
//   cur!=stop: apply next = up ? min(cur+step,stop) : max(cur-step,stop). Sum/difference uses FREQ_W+1 bits (no wrap).
//   cur==stop, mode_loop=0: busy=0, done=1 next cycle; state=IDLE; freq_C2 holds stop.
//   cur==stop, mode_loop=1: apply f_start again; no done pulse.
//  Timing: consecutive freq_valid pulses exactly max(dwell,1) cycles apart.
//   done occurs max(dwell,1) cycles after the last freq_valid.
//  f_start==f_stop: one point only, then done (or that point repeats in loop mode).
//  abort in DWELL: next cycle state=IDLE, busy=0; no done, no freq_valid; freq_C2 holds.
//   abort has priority over dwell expiry in the same cycle. abort in IDLE has no effect.
//  reset mid-sweep: all outputs return to reset values on the next edge.
// CONFIGURATION
//  DDFS_SWEEP_PAUSE_EN defined: adds input port 'pause' (1 bit).
//   While pause=1 in DWELL, cnt freezes and no frequency advances; busy stays 1.
//   abort still works while paused. pause is ignored in IDLE.
//  Not defined: no pause port; dwell always counts every cycle.
// TESTING
//  1 up sweep 1000->1300, step 100, dwell 3 (start at cycle 0) -> freq_valid at cycles 1,4,7,10 with 1000,1100,1200,1300; done at cycle 13; busy low from 13.
//  2 down clamp 5000->4850, step 100, dwell 0 -> 5000,4900,4850 on consecutive cycles; done the cycle after 4850.
//  3 illegal f_stop=5000001 -> err pulse 1 cycle; busy=0; freq_C2 unchanged. Repeat with step=0, start=100, stop=200 -> err.
//  4 abort during 2nd dwell of test 1 -> busy=0 next cycle; freq_C2=1100 held; no done. Following start is accepted.
//  5 loop 100->200, step 100, dwell 2 -> 100,200,100,200 every 2 cycles; start while busy ignored; abort ends.
//  6 reset mid-sweep -> freq_C2=0, all flags 0 next cycle. With DDFS_SWEEP_PAUSE_EN: pause 5 cycles stretches the current dwell by 5.

Source files
------------

// File: rtl/ddfs_sweep_controller.sv
// Linear frequency sweep sequencer feeding freq_C2 of the DDFS frequency converter.
// Optional pause input is enabled by defining DDFS_SWEEP_PAUSE_EN.
module ddfs_sweep_controller #(
    parameter int FREQ_W   = 23,
    parameter int DWELL_W  = 24,
    parameter int MAX_FREQ = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               mode_loop,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DDFS_SWEEP_PAUSE_EN
    input  logic               pause,
`endif
    output logic [FREQ_W-1:0]  freq_C2,
    output logic               freq_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [FREQ_W-1:0]  MAX_F     = FREQ_W'(MAX_FREQ);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [FREQ_W-1:0]  fstart_q, fstart_d;
    logic [FREQ_W-1:0]  fstop_q, fstop_d;
    logic [FREQ_W-1:0]  fstep_q, fstep_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic               up_q, up_d;

    logic               pause_s;
    logic               illegal_s;
    logic [DWELL_W-1:0] dwell_eff_s;
    logic [FREQ_W:0]    sum_s;
    logic [FREQ_W:0]    diff_s;
    logic [FREQ_W-1:0]  next_freq_s;

`ifdef DDFS_SWEEP_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    assign illegal_s   = (f_start > MAX_F) || (f_stop > MAX_F) ||
                         ((f_step == {FREQ_W{1'b0}}) && (f_start != f_stop));
    assign dwell_eff_s = (dwell == {DWELL_W{1'b0}}) ? DWELL_ONE : dwell;

    // One extra bit keeps the step from wrapping; the result is clamped to the stop value.
    always_comb begin
        sum_s  = {1'b0, freq_q} + {1'b0, fstep_q};
        diff_s = {1'b0, freq_q} - {1'b0, fstep_q};
        if (up_q) begin
            if (sum_s >= {1'b0, fstop_q}) begin
                next_freq_s = fstop_q;
            end else begin
                next_freq_s = sum_s[FREQ_W-1:0];
            end
        end else begin
            if (diff_s[FREQ_W] || (diff_s[FREQ_W-1:0] <= fstop_q)) begin
                next_freq_s = fstop_q;
            end else begin
                next_freq_s = diff_s[FREQ_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        fstart_d = fstart_q;
        fstop_d  = fstop_q;
        fstep_d  = fstep_q;
        dwell_d  = dwell_q;
        loop_d   = loop_q;
        up_d     = up_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (illegal_s) begin
                        err_d = 1'b1;
                    end else begin
                        fstart_d = f_start;
                        fstop_d  = f_stop;
                        fstep_d  = f_step;
                        dwell_d  = dwell_eff_s;
                        loop_d   = mode_loop;
                        up_d     = (f_stop >= f_start);
                        freq_d   = f_start;
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = dwell_eff_s;
                        state_d  = ST_DWELL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = {DWELL_W{1'b0}};
                end else if (pause_s) begin
                    cnt_d = cnt_q;
                end else if (cnt_q <= DWELL_ONE) begin
                    // Dwell expiry: advance, wrap to start, or finish.
                    if (freq_q != fstop_q) begin
                        freq_d  = next_freq_s;
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
                    end else if (loop_q) begin
                        freq_d  = fstart_q;
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = {DWELL_W{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = {DWELL_W{1'b0}};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            freq_q   <= {FREQ_W{1'b0}};
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= {DWELL_W{1'b0}};
            fstart_q <= {FREQ_W{1'b0}};
            fstop_q  <= {FREQ_W{1'b0}};
            fstep_q  <= {FREQ_W{1'b0}};
            dwell_q  <= {DWELL_W{1'b0}};
            loop_q   <= 1'b0;
            up_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            fstart_q <= fstart_d;
            fstop_q  <= fstop_d;
            fstep_q  <= fstep_d;
            dwell_q  <= dwell_d;
            loop_q   <= loop_d;
            up_q     <= up_d;
        end
    end

    assign freq_C2    = freq_q;
    assign freq_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ddfs_sweep_controller.sv
// Directed self-checking bench for ddfs_sweep_controller (pause scenario under DDFS_SWEEP_PAUSE_EN).
module tb_ddfs_sweep_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode_loop;
    logic        pause;
    logic [22:0] f_start;
    logic [22:0] f_stop;
    logic [22:0] f_step;
    logic [23:0] dwell;
    logic [22:0] freq_C2;
    logic        freq_valid;
    logic        busy;
    logic        done;
    logic        err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    ddfs_sweep_controller dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode_loop (mode_loop),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
`ifdef DDFS_SWEEP_PAUSE_EN
        .pause     (pause),
`endif
        .freq_C2   (freq_C2),
        .freq_valid(freq_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic set_cfg(input int s, input int p, input int st, input int d, input logic lp);
        f_start   = 23'(s);
        f_stop    = 23'(p);
        f_step    = 23'(st);
        dwell     = 24'(d);
        mode_loop = lp;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({freq_valid, busy, done, err, freq_C2} !== {4'b0000, 23'd0}) begin
            miss_cnt++;
            $display("FAIL reset: got v%b b%b d%b e%b f%0d, want all 0",
                     freq_valid, busy, done, err, freq_C2);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_up_sweep;
        logic [26:0] expv;
        int          ef;
        set_cfg(1000, 1300, 100, 3, 1'b0);
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            ef   = 1000 + 100 * (((k <= 10) ? k - 1 : 9) / 3);
            expv = {((k <= 10) && ((k - 1) % 3 == 0)), (k < 13), (k == 13), 1'b0, 23'(ef)};
            vec_cnt++;
            if ({freq_valid, busy, done, err, freq_C2} !== expv) begin
                miss_cnt++;
                $display("FAIL up_sweep c%0d: got v%b b%b d%b e%b f%0d, want v%b b%b d%b e%b f%0d",
                         k, freq_valid, busy, done, err, freq_C2,
                         expv[26], expv[25], expv[24], expv[23], expv[22:0]);
            end
        end
    endtask

    task automatic test_down_clamp;
        int          ef [5];
        logic [4:0]  ev;
        logic [4:0]  eb;
        logic [4:0]  ed;
        logic [26:0] expv;
        ef = '{5000, 4900, 4850, 4850, 4850};
        ev = 5'b00111;
        eb = 5'b00111;
        ed = 5'b01000;
        set_cfg(5000, 4850, 100, 0, 1'b0);
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            expv = {ev[k], eb[k], ed[k], 1'b0, 23'(ef[k])};
            vec_cnt++;
            if ({freq_valid, busy, done, err, freq_C2} !== expv) begin
                miss_cnt++;
                $display("FAIL down_clamp c%0d: got v%b b%b d%b e%b f%0d, want v%b b%b d%b e%b f%0d",
                         k + 1, freq_valid, busy, done, err, freq_C2,
                         expv[26], expv[25], expv[24], expv[23], expv[22:0]);
            end
        end
    endtask

    task automatic test_illegal;
        logic [26:0] expv;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) set_cfg(100, 5000001, 100, 3, 1'b0);
            else        set_cfg(100, 200, 0, 3, 1'b0);
            start = 1'b1;
            for (int k = 1; k <= 2; k++) begin
                @(negedge clk);
                start = 1'b0;
                expv = {1'b0, 1'b0, 1'b0, (k == 1), 23'd4850};
                vec_cnt++;
                if ({freq_valid, busy, done, err, freq_C2} !== expv) begin
                    miss_cnt++;
                    $display("FAIL illegal%0d c%0d: got v%b b%b d%b e%b f%0d, want v0 b0 d0 e%b f4850",
                             t, k, freq_valid, busy, done, err, freq_C2, expv[23]);
                end
            end
        end
    endtask

    task automatic test_abort;
        logic [26:0] expv;
        int          ef;
        set_cfg(1000, 1300, 100, 3, 1'b0);
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            ef   = (k <= 3) ? 1000 : 1100;
            expv = {((k == 1) || (k == 4)), (k <= 5), 1'b0, 1'b0, 23'(ef)};
            vec_cnt++;
            if ({freq_valid, busy, done, err, freq_C2} !== expv) begin
                miss_cnt++;
                $display("FAIL abort c%0d: got v%b b%b d%b e%b f%0d, want v%b b%b d0 e0 f%0d",
                         k, freq_valid, busy, done, err, freq_C2, expv[26], expv[25], ef);
            end
            if (k == 5) abort = 1'b1;
        end
        // single-point sweep right after the abort
        set_cfg(1000, 1000, 100, 1, 1'b0);
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            expv = {(k == 1), (k == 1), (k == 2), 1'b0, 23'd1000};
            vec_cnt++;
            if ({freq_valid, busy, done, err, freq_C2} !== expv) begin
                miss_cnt++;
                $display("FAIL single_point c%0d: got v%b b%b d%b e%b f%0d, want v%b b%b d%b e0 f1000",
                         k, freq_valid, busy, done, err, freq_C2, expv[26], expv[25], expv[24]);
            end
        end
    endtask

    task automatic test_loop;
        logic [26:0] expv;
        int          ef;
        set_cfg(100, 200, 100, 2, 1'b1);
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            ef   = (k <= 2 || k == 5 || k == 6) ? 100 : 200;
            expv = {((k % 2 == 1) && (k <= 7)), (k <= 8), 1'b0, 1'b0, 23'(ef)};
            vec_cnt++;
            if ({freq_valid, busy, done, err, freq_C2} !== expv) begin
                miss_cnt++;
                $display("FAIL loop c%0d: got v%b b%b d%b e%b f%0d, want v%b b%b d0 e0 f%0d",
                         k, freq_valid, busy, done, err, freq_C2, expv[26], expv[25], ef);
            end
            if (k == 2) begin
                set_cfg(300, 400, 100, 5, 1'b0);
                start = 1'b1;
            end
            if (k == 8) abort = 1'b1;
        end
    endtask

    task automatic test_reset_mid;
        logic [26:0] expv;
        set_cfg(1000, 1300, 100, 3, 1'b0);
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                expv = {1'b1, 1'b1, 1'b0, 1'b0, 23'd1000};
                vec_cnt++;
                if ({freq_valid, busy, done, err, freq_C2} !== expv) begin
                    miss_cnt++;
                    $display("FAIL reset_mid_start: got v%b b%b f%0d, want v1 b1 f1000",
                             freq_valid, busy, freq_C2);
                end
            end
            if (k == 6) begin
                vec_cnt++;
                if ({freq_valid, busy, done, err, freq_C2} !== {4'b0000, 23'd0}) begin
                    miss_cnt++;
                    $display("FAIL reset_mid: got v%b b%b d%b e%b f%0d, want all 0",
                             freq_valid, busy, done, err, freq_C2);
                end
            end
            if (k == 5) reset = 1'b1;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef DDFS_SWEEP_PAUSE_EN
    task automatic test_pause;
        logic [26:0] expv;
        int          ef;
        set_cfg(1000, 1300, 100, 3, 1'b0);
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            ef   = (k < 9) ? 1000 : 1100;
            expv = {((k == 1) || (k == 9)), 1'b1, 1'b0, 1'b0, 23'(ef)};
            vec_cnt++;
            if ({freq_valid, busy, done, err, freq_C2} !== expv) begin
                miss_cnt++;
                $display("FAIL pause c%0d: got v%b b%b d%b e%b f%0d, want v%b b1 d0 e0 f%0d",
                         k, freq_valid, busy, done, err, freq_C2, expv[26], ef);
            end
            pause = (k >= 2) && (k <= 6);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vec_cnt++;
        if ({busy, done} !== 2'b00) begin
            miss_cnt++;
            $display("FAIL pause_abort: got b%b d%b, want b0 d0", busy, done);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_up_sweep;
        test_down_clamp;
        test_illegal;
        test_abort;
        test_loop;
        test_reset_mid;
`ifdef DDFS_SWEEP_PAUSE_EN
        test_pause;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
